// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the FIFO read arbiter: FSM state encoding and default burst size.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2,
    TAIL  = 2'd3
  } arb_state_t;

  localparam int unsigned DEFAULT_BURST_LEN = 16;

endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after rr_ptr, searching upward with wrap.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               found
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin owner of a tracking FIFO's read port; grants whole bursts only when the FIFO
// already holds them, and steers each returned byte to the granted requester.
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BURST_LEN  = DEFAULT_BURST_LEN,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  flush,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    data_valid,
  output logic [7:0]            data,
  output logic                  fifo_read,
  input  logic [7:0]            fifo_data,
  input  logic [ADDR_WIDTH-1:0] fifo_addr_in,
  input  logic [ADDR_WIDTH-1:0] fifo_addr_out,
  output logic [ADDR_WIDTH-1:0] level,
  output logic                  busy
);

  localparam int unsigned           IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] BURST_LVL   = ADDR_WIDTH'(BURST_LEN);
  localparam logic [7:0]            BURST_BEATS = 8'(BURST_LEN);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_REQ - 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [7:0]         beat_cnt;
  logic               rd_d1;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               full_burst;
  logic               start;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner     (pick_oh),
    .winner_idx (pick_idx),
    .found      (pick_found)
  );

  always_comb begin
    full_burst = (level >= BURST_LVL);
    start      = pick_found && (full_burst || (flush && (level != '0)));
  end

  // Modulo subtraction handles the address wrap without special casing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else begin
      level <= fifo_addr_in - fifo_addr_out;
    end
  end

  // Winner and beat count are latched on the IDLE->GRANT edge so grant is already a
  // registered output during the GRANT cycle; grant stays valid through TAIL, which is
  // also the edge that launches the final data_valid strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      data_valid <= '0;
      data       <= '0;
      fifo_read  <= 1'b0;
      busy       <= 1'b0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      rd_d1      <= 1'b0;
    end else begin
      rd_d1 <= fifo_read;
      if (rd_d1) begin
        data       <= fifo_data;
        data_valid <= grant;
      end else begin
        data_valid <= '0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= GRANT;
            busy     <= 1'b1;
            grant    <= pick_oh;
            rr_ptr   <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            beat_cnt <= full_burst ? BURST_BEATS : 8'(level);
          end
        end
        GRANT: begin
          state     <= BURST;
          fifo_read <= (beat_cnt != '0);
        end
        BURST: begin
          if (beat_cnt <= 8'd1) begin
            beat_cnt  <= '0;
            fifo_read <= 1'b0;
            state     <= TAIL;
          end else begin
            beat_cnt <= beat_cnt - 8'd1;
          end
        end
        TAIL: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant     <= '0;
          fifo_read <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
